// File: rtl/multiplication_pkg.sv
// multiplication_pkg: shared width defaults and FSM encoding for the
// shift-and-add multiplier (the divider uses the same width constants).
// Contents: NWIDTH_DEF, DWIDTH_DEF, PWIDTH_DEF, state_t.
package multiplication_pkg;

   // Width of the q operand / divider n and q.
   localparam int NWIDTH_DEF = 32;
   // Width of the d and r operands / divider d; also the iteration count.
   localparam int DWIDTH_DEF = 16;
   // Full product width; q*d+r can never exceed this, so no wrap is possible.
   localparam int PWIDTH_DEF = NWIDTH_DEF + DWIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : multiplication_pkg

// File: rtl/multiplication_if.sv
// multiplication_if: request/result bundle between a requester and the multiplier.
// master: drives start, q, d, r; sees product, overflow, busy, isDone.
// slave : the multiplier side of the same signals.
interface multiplication_if #(
   parameter int NWIDTH = multiplication_pkg::NWIDTH_DEF,
   parameter int DWIDTH = multiplication_pkg::DWIDTH_DEF
) ();

   // All vectors are ordinary binary values with the MSB leftmost.
   logic                     start;
   logic [NWIDTH-1:0]        q;
   logic [DWIDTH-1:0]        d;
   logic [DWIDTH-1:0]        r;
   logic [NWIDTH+DWIDTH-1:0] product;
   logic                     overflow;
   logic                     busy;
   logic                     isDone;

   modport master (
      output start, q, d, r,
      input  product, overflow, busy, isDone
   );

   modport slave (
      input  start, q, d, r,
      output product, overflow, busy, isDone
   );

endinterface : multiplication_if

// File: rtl/multiplication.sv
// multiplication: sequential shift-and-add multiplier, product = q*d + r.
// Ports: clk, reset (sync, active-high), bus (slave modport: start/q/d/r in,
//        product/overflow/busy/isDone out). Latency DWIDTH+1 edges, fixed.
module multiplication
   import multiplication_pkg::*;
#(
   parameter int NWIDTH = NWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   multiplication_if.slave  bus
);

   localparam int PWIDTH = NWIDTH + DWIDTH;
   localparam int CW     = $clog2(DWIDTH);

   state_t              state_q, state_d;
   logic [PWIDTH-1:0]   acc_q, acc_d;
   // Multiplicand pre-shifted by the current bit position, so each step is a
   // plain add instead of a variable shifter.
   logic [PWIDTH-1:0]   mcand_q, mcand_d;
   // Multiplier shifted right each step; bit 0 is always the bit being processed.
   logic [DWIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PWIDTH-1:0]   product_q, product_d;
   logic                overflow_q, overflow_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PWIDTH-1:0]   step_sum;

   // Accumulator value including the current step.
   assign step_sum = acc_q + (mplier_q[0] ? mcand_q : {PWIDTH{1'b0}});

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         product_q  <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         product_q  <= product_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      product_d  = product_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = done_q;

      case (state_q)
         // DONE accepts a new request exactly like IDLE; product is left
         // untouched until the new result completes.
         IDLE, DONE: begin
            if (bus.start) begin
               mcand_d  = PWIDTH'(bus.q);
               mplier_d = bus.d;
               acc_d    = PWIDTH'(bus.r);
               cnt_d    = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               state_d  = RUN;
            end
         end

         RUN: begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(DWIDTH - 1)) begin
               product_d  = step_sum;
               overflow_d = |step_sum[PWIDTH-1:NWIDTH];
               busy_d     = 1'b0;
               done_d     = 1'b1;
               cnt_d      = '0;
               state_d    = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.product  = product_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;
   assign bus.isDone   = done_q;

endmodule : multiplication

// File: tb/tb_multiplication.sv
// tb_multiplication: directed vector table plus hand-written handshake
// sequences for the shift-and-add multiplier; expected values are hand-computed.
module tb_multiplication;
   import multiplication_pkg::*;

   localparam int NW = NWIDTH_DEF;
   localparam int DW = DWIDTH_DEF;
   localparam int PW = PWIDTH_DEF;

   logic clk;
   logic reset;

   multiplication_if #(.NWIDTH(NW), .DWIDTH(DW)) bus ();

   multiplication #(.NWIDTH(NW), .DWIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [NW-1:0] q;
      logic [DW-1:0] d;
      logic [DW-1:0] r;
      logic [PW-1:0] exp_p;
      logic          exp_o;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Advance one edge and settle outputs before sampling / driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation from a start pulse: checks busy over the whole run,
   // no early isDone, and the result exactly after edge DW+1.
   task automatic run_op(input string name, input logic [NW-1:0] q, input logic [DW-1:0] d,
                         input logic [DW-1:0] r, input logic [PW-1:0] exp_p, input logic exp_o);
      int bad;
      bus.start = 1'b1; bus.q = q; bus.d = d; bus.r = r;
      tick();                                   // edge 1
      bus.start = 1'b0;
      bus.q = $urandom; bus.d = DW'($urandom); bus.r = DW'($urandom);
      bad = 0;
      for (int e = 2; e <= DW; e++) begin
         if (bus.busy !== 1'b1 || bus.isDone !== 1'b0) bad++;
         tick();
      end
      if (bus.busy !== 1'b1 || bus.isDone !== 1'b0) bad++;
      check({name, " busy_window"}, 64'(bad), 64'd0);
      tick();                                   // edge DW+1
      check({name, " isDone"}, 64'(bus.isDone), 64'd1);
      check({name, " busy_low"}, 64'(bus.busy), 64'd0);
      check({name, " product"}, 64'(bus.product), 64'(exp_p));
      check({name, " overflow"}, 64'(bus.overflow), 64'(exp_o));
   endtask

   initial begin
      vecs[0] = '{q: 32'd5,          d: 16'd3,      r: 16'd2,      exp_p: 48'd17,             exp_o: 1'b0};
      vecs[1] = '{q: 32'd142,        d: 16'd7,      r: 16'd6,      exp_p: 48'd1000,           exp_o: 1'b0};
      vecs[2] = '{q: 32'hFFFF_FFFF,  d: 16'hFFFF,   r: 16'hFFFF,   exp_p: 48'hFFFF_0000_0000, exp_o: 1'b1};
      vecs[3] = '{q: 32'd1234,       d: 16'd0,      r: 16'd7,      exp_p: 48'd7,              exp_o: 1'b0};
      vecs[4] = '{q: 32'd0,          d: 16'hABCD,   r: 16'h1234,   exp_p: 48'h1234,           exp_o: 1'b0};
      vecs[5] = '{q: 32'h0001_0000,  d: 16'h0010,   r: 16'd0,      exp_p: 48'h10_0000,        exp_o: 1'b0};
      vecs[6] = '{q: 32'h8000_0000,  d: 16'd2,      r: 16'd0,      exp_p: 48'h1_0000_0000,    exp_o: 1'b1};
      vecs[7] = '{q: 32'h1234_5678,  d: 16'h0100,   r: 16'h0055,   exp_p: 48'h12_3456_7855,   exp_o: 1'b1};

      reset = 1'b1;
      bus.start = 1'b0; bus.q = '0; bus.d = '0; bus.r = '0;
      tick(); tick();
      reset = 1'b0;
      check("reset product", 64'(bus.product), 64'd0);
      check("reset overflow", 64'(bus.overflow), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset isDone", 64'(bus.isDone), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].exp_p, vecs[i].exp_o);
         tick();
         check($sformatf("vec%0d hold", i), 64'(bus.product), 64'(vecs[i].exp_p));
      end

      // Reset mid-run: start on edge 1, reset sampled on edge 8.
      bus.start = 1'b1; bus.q = 32'd100; bus.d = 16'd100; bus.r = '0;
      tick();
      bus.start = 1'b0;
      for (int e = 2; e <= 7; e++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midreset busy", 64'(bus.busy), 64'd0);
      check("midreset isDone", 64'(bus.isDone), 64'd0);
      check("midreset product", 64'(bus.product), 64'd0);
      run_op("after_reset", 32'd2, 16'd3, 16'd1, 48'd7, 1'b0);

      // start held through RUN with changing operands: first operands win.
      bus.start = 1'b1; bus.q = 32'd10; bus.d = 16'd10; bus.r = 16'd0;
      tick();
      for (int e = 2; e <= DW + 1; e++) begin
         bus.q = 32'd3; bus.d = 16'd3; bus.r = 16'd9;
         tick();
      end
      bus.start = 1'b0;
      check("held isDone", 64'(bus.isDone), 64'd1);
      check("held product", 64'(bus.product), 64'd100);

      // start in DONE: busy rises at once, old product holds until completion.
      bus.start = 1'b1; bus.q = 32'd6; bus.d = 16'd7; bus.r = 16'd0;
      tick();
      bus.start = 1'b0;
      check("restart busy", 64'(bus.busy), 64'd1);
      check("restart isDone", 64'(bus.isDone), 64'd0);
      check("restart old product", 64'(bus.product), 64'd100);
      for (int e = 2; e <= DW; e++) tick();
      check("restart product e16", 64'(bus.product), 64'd100);
      tick();
      check("restart product", 64'(bus.product), 64'd42);
      check("restart done", 64'(bus.isDone), 64'd1);

      // start and reset on the same edge after an overflowing result.
      run_op("pre_sr", 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000, 1'b1);
      bus.start = 1'b1; reset = 1'b1;
      tick();
      bus.start = 1'b0; reset = 1'b0;
      check("start+reset busy", 64'(bus.busy), 64'd0);
      check("start+reset isDone", 64'(bus.isDone), 64'd0);
      check("start+reset product", 64'(bus.product), 64'd0);
      check("start+reset overflow", 64'(bus.overflow), 64'd0);
      tick();
      check("start+reset stays idle", 64'(bus.busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_multiplication
